iter_colorizer: RTL and testbench

//  Colour stage between the iteration-count pixel stream and the 256-entry palette ROM.

---
 rtl/iter_colorizer.sv | 126 ++++++++++++
 tb/tb_iter_colorizer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_colorizer.sv
// Colour stage: iteration count -> palette index -> ROM address, with colour
// cycling and a two-slot pipeline that hides the ROM's one-cycle read latency.
module iter_colorizer #(
    parameter int ITER_W     = 16,
    parameter int CYCLE_DIV  = 4,
    parameter int CYCLE_STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              cycle_en,
    input  logic [ITER_W-1:0] max_iter,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ITER_W-1:0] in_iter,
    output logic [7:0]        pal_addr,
    input  logic [23:0]       pal_rgb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [23:0]       out_rgb
);

    localparam int FC_W = (CYCLE_DIV > 1) ? $clog2(CYCLE_DIV) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(CYCLE_DIV - 1);
    localparam logic [8:0] STEP9 = 9'(CYCLE_STEP);

    logic            v1_q, v1_d;
    logic            v2_q, v2_d;
    logic            hold_sel_q, hold_sel_d;
    logic [7:0]      pal_addr_q, pal_addr_d;
    logic [7:0]      offset_q, offset_d;
    logic [FC_W-1:0] fc_q, fc_d;
    logic [23:0]     hold_q, hold_d;

    logic [8:0] s;
    logic [8:0] step_s;
    logic [7:0] idx;
    logic       adv;
    logic       accept;
    logic       out_hs;

    // 1 + (s mod 255) folded into one add per branch
    always_comb begin
        s = {1'b0, in_iter[7:0]} + {1'b0, offset_q};
        if (in_iter >= max_iter) begin
            idx = 8'd0;
        end else if (s >= 9'd255) begin
            idx = 8'(s - 9'd254);
        end else begin
            idx = 8'(s + 9'd1);
        end
    end

    always_comb begin
        step_s   = {1'b0, offset_q} + STEP9;
        fc_d     = fc_q;
        offset_d = offset_q;
        if (frame_start) begin
            if (fc_q == FC_LAST) begin
                fc_d = '0;
                if (cycle_en) begin
                    offset_d = (step_s >= 9'd255) ? 8'(step_s - 9'd255)
                                                  : step_s[7:0];
                end
            end else begin
                fc_d = fc_q + FC_W'(1);
            end
        end
    end

    assign in_ready = ~v1_q | ~v2_q | out_ready;
    assign adv      = v1_q & (~v2_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign out_hs   = v2_q & out_ready;

    always_comb begin
        v1_d       = v1_q;
        v2_d       = v2_q;
        pal_addr_d = pal_addr_q;
        hold_sel_d = hold_sel_q;
        hold_d     = hold_q;
        if (accept) begin
            pal_addr_d = idx;
            v1_d       = 1'b1;
        end else if (adv) begin
            v1_d = 1'b0;
        end
        if (adv) begin
            v2_d = 1'b1;
        end else if (out_hs) begin
            v2_d = 1'b0;
        end
        // ROM re-reads pal_addr each cycle, so freeze the S2 colour on stall
        if (out_hs) begin
            hold_sel_d = 1'b0;
        end else if (v2_q & ~out_ready & ~hold_sel_q) begin
            hold_sel_d = 1'b1;
            hold_d     = pal_rgb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            hold_sel_q <= 1'b0;
            pal_addr_q <= 8'd0;
            offset_q   <= 8'd0;
            fc_q       <= '0;
            hold_q     <= 24'd0;
        end else begin
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            hold_sel_q <= hold_sel_d;
            pal_addr_q <= pal_addr_d;
            offset_q   <= offset_d;
            fc_q       <= fc_d;
            hold_q     <= hold_d;
        end
    end

    assign pal_addr  = pal_addr_q;
    assign out_valid = v2_q;
    assign out_rgb   = ~v2_q ? 24'd0 : (hold_sel_q ? hold_q : pal_rgb);

endmodule

// File: tb/tb_iter_colorizer.sv
// Bench for iter_colorizer: directed scenarios plus a scoreboard fed by a
// palette ROM model and an arithmetic index/offset reference.
module tb_iter_colorizer;

    localparam int DIV  = 4;
    localparam int STEP = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        cycle_en;
    logic [15:0] max_iter;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_iter;
    logic [7:0]  pal_addr;
    logic [23:0] pal_rgb;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_rgb;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;

    logic [23:0] rom [256];
    logic [23:0] exp_q [$];
    int off_m = 0;
    int fc_m  = 0;

    iter_colorizer #(.ITER_W(16), .CYCLE_DIV(DIV), .CYCLE_STEP(STEP)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .cycle_en(cycle_en),
        .max_iter(max_iter), .in_valid(in_valid), .in_ready(in_ready),
        .in_iter(in_iter), .pal_addr(pal_addr), .pal_rgb(pal_rgb),
        .out_valid(out_valid), .out_ready(out_ready), .out_rgb(out_rgb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pal_rgb <= rom[pal_addr];

    function automatic int idx_ref(input int it, input int mx, input int off);
        if (it >= mx) return 0;
        return 1 + (((it % 256) + off) % 255);
    endfunction

    // Scoreboard: in-flight pixels are those accepted but not yet delivered
    always @(negedge clk) begin
        int n;
        logic [23:0] e;
        if (rst) begin
            exp_q.delete();
            off_m = 0;
            fc_m  = 0;
        end else begin
            n = exp_q.size();
            n_tests++;
            if (in_ready !== ((n == 2 && !out_ready) ? 1'b0 : 1'b1)) begin
                n_fail++;
                $display("FAIL in_ready: got %b with %0d in flight, out_ready=%b",
                         in_ready, n, out_ready);
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (n == 0) begin
                    n_fail++;
                    $display("FAIL dup_out: got %h with nothing in flight", out_rgb);
                end else begin
                    e = exp_q.pop_front();
                    n_out++;
                    if (out_rgb !== e) begin
                        n_fail++;
                        $display("FAIL out_rgb: got %h expected %h", out_rgb, e);
                    end
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(rom[idx_ref(int'(in_iter), int'(max_iter), off_m)]);
            if (frame_start) begin
                fc_m = (fc_m + 1) % DIV;
                if (fc_m == 0 && cycle_en) off_m = (off_m + STEP) % 255;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        frame_start = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic send(input logic [15:0] it);
        int k;
        logic acc;
        in_valid = 1'b1;
        in_iter  = it;
        k = 0;
        acc = 1'b0;
        while (!acc && k < 50) begin
            @(negedge clk);
            acc = in_ready;
            step();
            k++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: iter %0d never accepted", it);
        end
    endtask

    task automatic check_addr(input string nm, input logic [7:0] e);
        n_tests++;
        if (pal_addr !== e) begin
            n_fail++;
            $display("FAIL %s: pal_addr got %0d expected %0d", nm, pal_addr, e);
        end
    endtask

    task automatic drain();
        int k;
        out_ready = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            step();
            k++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d pixels lost", exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
            out_rgb !== 24'd0 || pal_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_rgb=%h pal_addr=%0d",
                     in_ready, out_valid, out_rgb, pal_addr);
        end
        step();
    endtask

    task automatic test_basic();
        int its [5];
        int ex [5];
        logic ov [5];
        its = '{0, 5, 99, 100, 4000};
        ex  = '{1, 6, 100, 0, 0};
        do_reset();
        max_iter = 16'd100;
        cycle_en = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_iter = 16'(its[i]);
            @(negedge clk);
            ov[i] = out_valid;
            step();
            check_addr("basic_idx", 8'(ex[i]));
        end
        in_valid = 1'b0;
        n_tests++;
        if (ov[0] !== 1'b0 || ov[1] !== 1'b0 || ov[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL latency: out_valid T,T+1,T+2 = %b%b%b expected 001",
                     ov[0], ov[1], ov[2]);
        end
        drain();
    endtask

    task automatic test_cycling();
        do_reset();
        max_iter = 16'hffff;
        out_ready = 1'b1;
        cycle_en = 1'b1;
        frame_start = 1'b1;
        repeat (8) step();
        frame_start = 1'b0;
        send(16'd254);
        check_addr("offset2", 8'd2);
        frame_start = 1'b1;
        repeat (252 * DIV) step();
        frame_start = 1'b0;
        send(16'd0);
        check_addr("offset254", 8'd255);
        frame_start = 1'b1;
        repeat (DIV) step();
        frame_start = 1'b0;
        send(16'd0);
        check_addr("offset_wrap", 8'd1);
        cycle_en = 1'b0;
        frame_start = 1'b1;
        repeat (2) step();
        cycle_en = 1'b1;
        repeat (2) step();
        frame_start = 1'b0;
        send(16'd0);
        check_addr("fc_counts_disabled", 8'd2);
        cycle_en = 1'b0;
        frame_start = 1'b1;
        repeat (DIV) step();
        frame_start = 1'b0;
        send(16'd0);
        check_addr("no_advance_disabled", 8'd2);
        drain();
    endtask

    task automatic test_back_to_back();
        int acc_cnt;
        int cyc;
        int base;
        logic acc;
        do_reset();
        max_iter = 16'($urandom_range(50, 300));
        cycle_en = 1'b1;
        base = n_out;
        acc_cnt = 0;
        cyc = 0;
        in_valid = 1'b1;
        in_iter = 16'($urandom_range(0, 400));
        while (acc_cnt < 64 && cyc < 2000) begin
            out_ready = 1'($urandom % 2);
            frame_start = ($urandom % 8) == 0;
            @(negedge clk);
            acc = in_ready;
            step();
            cyc++;
            if (acc) begin
                acc_cnt++;
                in_iter = 16'($urandom_range(0, 400));
            end
        end
        in_valid = 1'b0;
        frame_start = 1'b0;
        drain();
        n_tests++;
        if (n_out - base != 64) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d outputs expected 64", n_out - base);
        end
    endtask

    task automatic test_stall();
        int a;
        logic [23:0] ca;
        logic [23:0] cb;
        do_reset();
        max_iter = 16'd1000;
        cycle_en = 1'b0;
        out_ready = 1'b0;
        a = $urandom_range(0, 200);
        ca = rom[idx_ref(a, 1000, 0)];
        cb = rom[idx_ref(a + 1, 1000, 0)];
        send(16'(a));
        send(16'(a + 1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || out_rgb !== ca || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold: cyc %0d out_valid=%b out_rgb=%h expected %h in_ready=%b",
                         i, out_valid, out_rgb, ca, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || out_rgb !== ca) begin
            n_fail++;
            $display("FAIL release_s2: out_rgb=%h expected %h", out_rgb, ca);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || out_rgb !== cb) begin
            n_fail++;
            $display("FAIL release_s1: out_rgb=%h expected %h", out_rgb, cb);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release_empty: out_valid=%b expected 0", out_valid);
        end
        step();
    endtask

    task automatic test_reset_midstream();
        do_reset();
        max_iter = 16'd1000;
        cycle_en = 1'b1;
        out_ready = 1'b1;
        frame_start = 1'b1;
        repeat (DIV) step();
        frame_start = 1'b0;
        out_ready = 1'b0;
        send(16'd7);
        send(16'd8);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || out_rgb !== 24'd0 ||
            in_ready !== 1'b1 || pal_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reset: out_valid=%b out_rgb=%h in_ready=%b pal_addr=%0d",
                     out_valid, out_rgb, in_ready, pal_addr);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stale_pixel: out_valid=%b at cyc %0d expected 0", out_valid, i);
            end
            step();
        end
        send(16'd0);
        check_addr("offset_cleared", 8'd1);
        drain();
    endtask

    task automatic test_same_cycle();
        do_reset();
        max_iter = 16'd1000;
        cycle_en = 1'b1;
        out_ready = 1'b1;
        frame_start = 1'b1;
        repeat (DIV - 1) step();
        in_valid = 1'b1;
        in_iter = 16'd10;
        @(negedge clk);
        step();
        check_addr("old_offset", 8'd11);
        frame_start = 1'b0;
        @(negedge clk);
        step();
        check_addr("new_offset", 8'd12);
        in_valid = 1'b0;
        drain();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = {8'(i), 16'($urandom)};
        rst = 1'b1;
        frame_start = 1'b0;
        cycle_en = 1'b0;
        max_iter = 16'd100;
        in_valid = 1'b0;
        in_iter = 16'd0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_cycling();
        test_back_to_back();
        test_stall();
        test_reset_midstream();
        test_same_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
